// File: rtl/seg7_scan_mux_pkg.sv
// Shared constants and helpers for the four-digit seven-segment scan multiplexer.
package seg7_scan_mux_pkg;

   localparam int unsigned SEG_DIGITS = 4;
   localparam int unsigned NIB_W      = 4;
   localparam int unsigned IDX_W      = 2;
   localparam int unsigned VAL_W      = SEG_DIGITS * NIB_W;

   // Board pins are active-low: a driven 0 turns the anode or decimal point on.
   localparam logic ACTIVE_LOW_ON  = 1'b0;
   localparam logic ACTIVE_LOW_OFF = 1'b1;

   localparam logic [SEG_DIGITS-1:0] AN_ALL_OFF = 4'b1111;

   // Pick hex digit idx out of a packed 16-bit value; digit 0 is bits [3:0].
   function automatic logic [NIB_W-1:0] nibble_sel(input logic [VAL_W-1:0] val,
                                                   input logic [IDX_W-1:0] idx);
      return val[{idx, 2'b00} +: NIB_W];
   endfunction

endpackage : seg7_scan_mux_pkg

// File: rtl/seg7_refresh_prescaler.sv
// Refresh prescaler: free-running 0..REFRESH_DIV-1 counter that marks the
// last cycle of every digit slot.
//   clk        system clock
//   reset      synchronous, active-high
//   scan_tick  high during the cycle where the count equals REFRESH_DIV-1
module seg7_refresh_prescaler #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned CNT_W       = 17
) (
   input  logic clk,
   input  logic reset,
   output logic scan_tick
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

   if (REFRESH_DIV < 2) begin : g_bad_div
      $error("REFRESH_DIV must be at least 2");
   end
   if ((64'd1 << CNT_W) < 64'(REFRESH_DIV)) begin : g_bad_width
      $error("CNT_W too narrow for REFRESH_DIV");
   end

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Tick is decoded straight from the count so it lines up with the slot's last cycle.
   assign scan_tick = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (scan_tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : seg7_refresh_prescaler

// File: rtl/seg7_scan_mux.sv
// Time-multiplexes a 16-bit hex value onto a 4-digit common-anode display.
// New values are staged in a shadow register and committed only when the scan
// wraps from digit 3 to digit 0, so a frame never mixes old and new digits.
//   clk, reset   system clock, synchronous active-high reset
//   load         strobe capturing value_in/dp_in into the shadow registers
//   value_in     four hex digits, [3:0] is digit 0 (rightmost)
//   dp_in        decimal-point request per digit, active-high
//   blank_mask   per-digit forced blank, sampled live
//   lz_blank     enables leading-zero suppression
//   nibble       current digit value, feeds the hex-to-segment decoder
//   an           active-low anode enables, at most one low
//   dp           active-low decimal point
//   scan_tick    pulse on the last cycle of each digit slot (combinational)
module seg7_scan_mux
   import seg7_scan_mux_pkg::*;
#(
   parameter int unsigned DIGITS      = SEG_DIGITS,
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned CNT_W       = 17
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [VAL_W-1:0]      value_in,
   input  logic [SEG_DIGITS-1:0] dp_in,
   input  logic [SEG_DIGITS-1:0] blank_mask,
   input  logic                  lz_blank,
   output logic [NIB_W-1:0]      nibble,
   output logic [SEG_DIGITS-1:0] an,
   output logic                  dp,
   output logic                  scan_tick
);

   if (DIGITS != SEG_DIGITS) begin : g_bad_digits
      $error("DIGITS is fixed at 4 in this revision");
   end

   logic                  slot_end;

   logic [IDX_W-1:0]      idx_q,        idx_d;
   logic [VAL_W-1:0]      shadow_val_q, shadow_val_d;
   logic [SEG_DIGITS-1:0] shadow_dp_q,  shadow_dp_d;
   logic [VAL_W-1:0]      disp_val_q,   disp_val_d;
   logic [SEG_DIGITS-1:0] disp_dp_q,    disp_dp_d;
   logic [NIB_W-1:0]      nibble_q,     nibble_d;
   logic [SEG_DIGITS-1:0] an_q,         an_d;
   logic                  dp_q,         dp_d;

   logic                  frame_wrap;
   logic [SEG_DIGITS-1:0] lz_sup;
   logic                  digit_off;

   seg7_refresh_prescaler #(
      .REFRESH_DIV (REFRESH_DIV),
      .CNT_W       (CNT_W)
   ) u_prescaler (
      .clk       (clk),
      .reset     (reset),
      .scan_tick (slot_end)
   );

   assign scan_tick = slot_end;
   assign nibble    = nibble_q;
   assign an        = an_q;
   assign dp        = dp_q;

   // Leading-zero suppression: digit k goes dark when it and every digit above are zero.
   always_comb begin
      lz_sup    = '0;
      lz_sup[1] = lz_blank && (disp_val_q[15:4]  == 12'h000);
      lz_sup[2] = lz_blank && (disp_val_q[15:8]  == 8'h00);
      lz_sup[3] = lz_blank && (disp_val_q[15:12] == 4'h0);
   end

   // Index, shadow and frame-commit next state.
   always_comb begin
      idx_d        = idx_q;
      shadow_val_d = shadow_val_q;
      shadow_dp_d  = shadow_dp_q;
      disp_val_d   = disp_val_q;
      disp_dp_d    = disp_dp_q;
      frame_wrap   = slot_end && (idx_q == IDX_W'(SEG_DIGITS - 1));

      if (slot_end) begin
         idx_d = idx_q + IDX_W'(1);
      end
      // Commit reads the pre-edge shadow, so a coincident load lands one frame later.
      if (frame_wrap) begin
         disp_val_d = shadow_val_q;
         disp_dp_d  = shadow_dp_q;
      end
      if (load) begin
         shadow_val_d = value_in;
         shadow_dp_d  = dp_in;
      end
   end

   // Output stage, one cycle behind the index; nibble keeps the digit even when blanked.
   always_comb begin
      digit_off = blank_mask[idx_q] || lz_sup[idx_q];
      nibble_d  = nibble_sel(disp_val_q, idx_q);
      an_d      = AN_ALL_OFF;
      dp_d      = ACTIVE_LOW_OFF;
      if (!digit_off) begin
         an_d = ~(SEG_DIGITS'(1) << idx_q);
         dp_d = disp_dp_q[idx_q] ? ACTIVE_LOW_ON : ACTIVE_LOW_OFF;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx_q        <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         nibble_q     <= '0;
         an_q         <= AN_ALL_OFF;
         dp_q         <= ACTIVE_LOW_OFF;
      end else begin
         idx_q        <= idx_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         nibble_q     <= nibble_d;
         an_q         <= an_d;
         dp_q         <= dp_d;
      end
   end

endmodule : seg7_scan_mux

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux with a 4-cycle digit slot.
module tb_seg7_scan_mux;

   localparam int DIV   = 4;
   localparam int FRAME = 4 * DIV;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value_in = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  blank_mask = '0;
   logic        lz_blank = 1'b0;
   logic [3:0]  nibble;
   logic [3:0]  an;
   logic        dp;
   logic        scan_tick;

   int checks = 0;
   int errors = 0;

   seg7_scan_mux #(
      .DIGITS      (4),
      .REFRESH_DIV (DIV),
      .CNT_W       (3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .value_in   (value_in),
      .dp_in      (dp_in),
      .blank_mask (blank_mask),
      .lz_blank   (lz_blank),
      .nibble     (nibble),
      .an         (an),
      .dp         (dp),
      .scan_tick  (scan_tick)
   );

   always #5 clk = ~clk;

   // Reference model: everything follows from the number of cycles since reset.
   int          m_cyc = 0;
   int          m_k;
   bit          m_off;
   logic [15:0] m_shadow_val = '0, m_disp_val = '0;
   logic [3:0]  m_shadow_dp = '0, m_disp_dp = '0;
   logic [3:0]  exp_nib = '0;
   logic [3:0]  exp_an = 4'hF;
   logic        exp_dp = 1'b1;
   logic        exp_tick;

   assign exp_tick = ((m_cyc % DIV) == DIV - 1);

   always @(posedge clk) begin
      if (reset) begin
         m_cyc = 0;
         m_shadow_val = '0; m_shadow_dp = '0;
         m_disp_val = '0;   m_disp_dp = '0;
         exp_nib = '0; exp_an = 4'hF; exp_dp = 1'b1;
      end else begin
         m_k   = (m_cyc / DIV) % 4;
         m_off = blank_mask[m_k] || (lz_blank && m_k >= 1 && (m_disp_val >> (4 * m_k)) == 16'h0);
         exp_nib = 4'((m_disp_val >> (4 * m_k)) & 16'hF);
         exp_an  = m_off ? 4'hF : ~(4'(1) << m_k);
         exp_dp  = m_off ? 1'b1 : ~m_disp_dp[m_k];
         if ((m_cyc % FRAME) == FRAME - 1) begin
            m_disp_val = m_shadow_val;
            m_disp_dp  = m_shadow_dp;
         end
         if (load) begin
            m_shadow_val = value_in;
            m_shadow_dp  = dp_in;
         end
         m_cyc++;
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({nibble, an, dp, scan_tick} !== {4'h0, 4'b1111, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_state got nib=%h an=%b dp=%b tick=%b want nib=0 an=1111 dp=1 tick=0",
                  nibble, an, dp, scan_tick);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (an !== 4'b1110) begin
         errors++;
         $display("FAIL first_slot_an got %b want 1110", an);
      end
      for (int c = 0; c < 2 * FRAME; c++) begin
         @(negedge clk);
         checks++;
         if ({nibble, an, dp, scan_tick} !== {exp_nib, exp_an, exp_dp, exp_tick}) begin
            errors++;
            $display("FAIL idle_scan cyc=%0d got %h/%b/%b/%b want %h/%b/%b/%b",
                     m_cyc, nibble, an, dp, scan_tick, exp_nib, exp_an, exp_dp, exp_tick);
         end
      end
   endtask

   task automatic test_load_midframe();
      for (int c = 0; c < 3 * FRAME; c++) begin
         @(negedge clk);
         checks++;
         if ({nibble, an, dp, scan_tick} !== {exp_nib, exp_an, exp_dp, exp_tick}) begin
            errors++;
            $display("FAIL load_midframe cyc=%0d got %h/%b/%b/%b want %h/%b/%b/%b",
                     m_cyc, nibble, an, dp, scan_tick, exp_nib, exp_an, exp_dp, exp_tick);
         end
         load = (c == 5);
         value_in = 16'h1A2F;
      end
      load = 1'b0;
   endtask

   task automatic test_lz_blank();
      logic [15:0] vals [2] = '{16'h0005, 16'h0000};
      int lit_other;
      lz_blank = 1'b1;
      for (int v = 0; v < 2; v++) begin
         lit_other = 0;
         for (int c = 0; c < 3 * FRAME; c++) begin
            @(negedge clk);
            checks++;
            if ({nibble, an, dp, scan_tick} !== {exp_nib, exp_an, exp_dp, exp_tick}) begin
               errors++;
               $display("FAIL lz_blank v=%h cyc=%0d got %h/%b/%b want %h/%b/%b",
                        vals[v], m_cyc, nibble, an, dp, exp_nib, exp_an, exp_dp);
            end
            if (c >= 2 * FRAME && an !== 4'b1111 && !(an === 4'b1110 && nibble === vals[v][3:0]))
               lit_other++;
            load = (c == 0);
            value_in = vals[v];
         end
         checks++;
         if (lit_other !== 0) begin
            errors++;
            $display("FAIL lz_only_digit0 v=%h got %0d other lit cycles want 0", vals[v], lit_other);
         end
      end
      load = 1'b0;
      lz_blank = 1'b0;
   endtask

   task automatic test_blank_dp();
      blank_mask = 4'b0100;
      for (int c = 0; c < 3 * FRAME; c++) begin
         @(negedge clk);
         checks++;
         if ({nibble, an, dp, scan_tick} !== {exp_nib, exp_an, exp_dp, exp_tick}) begin
            errors++;
            $display("FAIL blank_dp cyc=%0d got %h/%b/%b want %h/%b/%b",
                     m_cyc, nibble, an, dp, exp_nib, exp_an, exp_dp);
         end
         load = (c == 0);
         value_in = 16'h1234;
         dp_in = 4'b0001;
      end
      load = 1'b0;
      blank_mask = 4'b0000;
   endtask

   task automatic test_back_to_back();
      logic [3:0] starts [$];
      logic [3:0] prev_an;
      int c = 0;
      while (c < FRAME && (m_cyc % FRAME) != FRAME - 1) begin
         @(negedge clk);
         c++;
         checks++;
         if ({nibble, an, dp, scan_tick} !== {exp_nib, exp_an, exp_dp, exp_tick}) begin
            errors++;
            $display("FAIL b2b_align cyc=%0d got %h/%b want %h/%b", m_cyc, nibble, an, exp_nib, exp_an);
         end
      end
      checks++;
      if ((m_cyc % FRAME) != FRAME - 1) begin
         errors++;
         $display("FAIL b2b_align_timeout got phase %0d want %0d", m_cyc % FRAME, FRAME - 1);
      end
      // The next edge is the 3->0 wrap; load lands on it.
      load = 1'b1;
      value_in = 16'hBEEF;
      dp_in = 4'b0000;
      prev_an = an;
      for (int k = 0; k < 2 * FRAME + 4; k++) begin
         @(negedge clk);
         load = 1'b0;
         checks++;
         if ({nibble, an, dp, scan_tick} !== {exp_nib, exp_an, exp_dp, exp_tick}) begin
            errors++;
            $display("FAIL b2b_scan cyc=%0d got %h/%b want %h/%b", m_cyc, nibble, an, exp_nib, exp_an);
         end
         if (an === 4'b1110 && prev_an !== 4'b1110) starts.push_back(nibble);
         prev_an = an;
      end
      checks++;
      if (starts.size() < 2 || starts[0] !== 4'h4 || starts[1] !== 4'hF) begin
         errors++;
         $display("FAIL b2b_frames got %0d starts first=%h second=%h want 4 then f",
                  starts.size(), (starts.size() > 0) ? starts[0] : 4'hx,
                  (starts.size() > 1) ? starts[1] : 4'hx);
      end
   endtask

   task automatic test_reset_midframe();
      int c = 0;
      int nz = 0;
      while (c < FRAME && (m_cyc % FRAME) != DIV) begin
         @(negedge clk);
         c++;
      end
      load = 1'b1;
      value_in = 16'h5A5A;
      @(negedge clk);
      load = 1'b0;
      c = 0;
      while (c < FRAME && (m_cyc % FRAME) != 2 * DIV + 1) begin
         @(negedge clk);
         c++;
      end
      checks++;
      if ((m_cyc % FRAME) != 2 * DIV + 1) begin
         errors++;
         $display("FAIL rst_mid_align_timeout got phase %0d want %0d", m_cyc % FRAME, 2 * DIV + 1);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (an !== 4'b1111 || nibble !== 4'h0) begin
         errors++;
         $display("FAIL rst_mid_state got an=%b nib=%h want an=1111 nib=0", an, nibble);
      end
      @(negedge clk);
      checks++;
      if (an !== 4'b1110 || nibble !== 4'h0) begin
         errors++;
         $display("FAIL rst_mid_restart got an=%b nib=%h want an=1110 nib=0", an, nibble);
      end
      for (int k = 0; k < 2 * FRAME; k++) begin
         @(negedge clk);
         if (nibble !== 4'h0) nz++;
         checks++;
         if ({nibble, an, dp, scan_tick} !== {exp_nib, exp_an, exp_dp, exp_tick}) begin
            errors++;
            $display("FAIL rst_mid_scan cyc=%0d got %h/%b want %h/%b", m_cyc, nibble, an, exp_nib, exp_an);
         end
      end
      checks++;
      if (nz !== 0) begin
         errors++;
         $display("FAIL rst_mid_discard got %0d nonzero nibble cycles want 0", nz);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         checks++;
         if ({nibble, an, dp, scan_tick} !== {exp_nib, exp_an, exp_dp, exp_tick}) begin
            errors++;
            $display("FAIL random cyc=%0d got %h/%b/%b/%b want %h/%b/%b/%b",
                     m_cyc, nibble, an, dp, scan_tick, exp_nib, exp_an, exp_dp, exp_tick);
         end
         checks++;
         if ($countones(~an) > 1) begin
            errors++;
            $display("FAIL onehot_an got %b want at most one low bit", an);
         end
         load       = ($urandom_range(0, 9) == 0);
         value_in   = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         dp_in      = 4'($urandom);
         blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         lz_blank   = 1'($urandom);
         reset      = ($urandom_range(0, 99) == 0);
      end
      reset = 1'b0;
      load = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_midframe();
      test_lz_blank();
      test_blank_dp();
      test_back_to_back();
      test_reset_midframe();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule : tb_seg7_scan_mux

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Time-multiplexes a 16-bit value (4 hex digits) onto a 4-digit common-anode seven-segment display.
- Sits directly upstream of the hex-to-7-segment decoder. It drives the decoder's 4-bit nibble input and drives the board's active-low anode and decimal-point pins.
- Provides tear-free updates by committing new values only at frame boundaries. Also provides per-digit blanking and optional leading-zero suppression.

Parameters:
- DIGITS, 4, number of scanned digits; fixed at 4 for this revision.
- REFRESH_DIV, 100000, clock cycles per digit slot (1 ms at 100 MHz); must be ≥2.
- CNT_W, 17, prescaler width; must satisfy 2^CNT_W ≥ REFRESH_DIV.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; captures value_in and dp_in into the shadow registers.
- value_in  in  16  four hex digits; [3:0] is digit 0 (rightmost).
- dp_in  in  4  decimal-point request per digit, active-high.
- blank_mask  in  4  1 blanks that digit unconditionally; sampled live, not shadowed.
- lz_blank  in  1  1 enables leading-zero suppression.
- nibble  out  4  hex digit for the current slot; feeds the decoder's x input.
- an  out  4  anode enables, active-low, one-hot-low.
- dp  out  1  decimal point, active-low.
- scan_tick  out  1  one-cycle pulse on the last cycle of each digit slot.

Behaviour:
- Reset (sync, while reset=1):
  - prescaler=0, digit index=0.
  - shadow value/dp=0; display value/dp=0.
  - an=4'b1111, nibble=4'h0, dp=1, scan_tick=0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and then wraps to 0.
  - scan_tick=1 exactly in the cycle where the count equals REFRESH_DIV-1. It is combinational from the count.
- Digit index:
  - 2-bit register that increments modulo 4 on the clock edge ending a scan_tick cycle. The sequence is 0,1,2,3,0,…
- Shadow register:
  - On a load edge, shadow_val<=value_in and shadow_dp<=dp_in.
  - Load is accepted in any cycle except during reset.
- Frame commit:
  - On the edge where the index wraps 3→0, display_val<=shadow_val and display_dp<=shadow_dp.
  - If load and the wrap edge coincide, display takes the OLD shadow contents. The new value appears after the next wrap.
- Leading-zero mask (combinational from display_val):
  - Digit k is suppressed when lz_blank=1, k≥1, and digits k..3 are all 4'h0.
  - Digit 0 is never suppressed by this rule, so value 0 shows a single "0".
- Output registers (all outputs except scan_tick), updated every cycle from the current index i:
  - nibble<=display_val[4i+3:4i].
  - an<=~(1<<i), or 4'b1111 if digit i is blanked (blank_mask[i] or LZ-suppressed).
  - dp<=~display_dp[i], or 1 if digit i is blanked.
  - nibble still carries the digit value when blanked.
- Latency:
  - Outputs lag the index by 1 cycle.
  - After reset deasserts, the first edge gives an=4'b1110.
  - A loaded value is visible no later than one full frame plus one slot: 5·REFRESH_DIV+1 cycles.
- Reset mid-frame:
  - Abandons the frame and discards any pending shadow value.
  - Scanning restarts at digit 0 with value 0.
- Only one an bit is ever low. No two digits are enabled in the same cycle.

Decomposition:
- Shared package holds:
  - SEG_DIGITS=4.
  - AN_ALL_OFF=4'b1111.
  - The active-low convention constants (ACTIVE_LOW_ON=1'b0).
  - A function nibble_sel(val,idx).
- One natural sub-module: seg7_refresh_prescaler (counter + scan_tick), parameterized by REFRESH_DIV/CNT_W.
- The top level instantiates the prescaler, holds the index, shadow and display registers, and drives the output registers.
- The decoder is instantiated by the parent, not inside this block.

Test Plan (sim with REFRESH_DIV=4):
- Reset release, no load → an cycles 1110,1101,1011,0111 every 4 cycles; nibble=0; dp=1; scan_tick pulses every 4th cycle.
- load value_in=16'h1A2F mid-frame → old value is shown until the 3→0 wrap. The next frame shows nibble F,2,A,1 with an 1110,1101,1011,0111.
- value 16'h0005, lz_blank=1 → an=1110 with nibble 5; the other slots show an=1111. With value 16'h0000, only digit 0 is lit with nibble 0.
- blank_mask=4'b0100, dp_in=4'b0001, value 16'h1234 → slot 2 shows an=1111 and dp=1; slot 0 shows dp=0; the other slots show dp=1.
- load asserted on the same edge as the 3→0 wrap (16'hBEEF over prior 16'h1234) → that frame shows 1234; the following frame shows BEEF.
- reset pulsed for 1 cycle during slot 2 → the next cycle shows an=1111, nibble=0. Then an=1110 follows and display_val=0 even though a load was pending in the shadow.
